snn_image_buf: RTL

Input-side responder for `snn_core`. It collects a 784-pixel binary image as 98 bytes from the UART receiver and stores it. Once the image is complete it pulses `start`, then answers the core's `addr_input_unit` requests with `q_input`. When the core signals `done`, it returns the classified digit to the UART transmitter as an ASCII character.

---
 rtl/snn_image_buf_pkg.sv | 12 +
 rtl/snn_image_buf_if.sv | 11 +
 rtl/snn_image_buf_ram.sv | 17 +
 rtl/snn_image_buf.sv | 58 +++++
 4 files changed

// File: rtl/snn_image_buf_pkg.sv
// snn_image_buf_pkg: shared FSM state type, image geometry constants and the digit-to-ASCII helper
package snn_image_buf_pkg;
  typedef enum logic [1:0] {LOAD, KICK, RUN, SEND} img_state_t;
  localparam int PIXELS = 784;
  localparam int NUM_BYTES = PIXELS / 8;
  localparam int ADDR_W = 10;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_ERR = 8'h3F;
  function automatic logic [7:0] to_ascii(input logic [3:0] d);
    return d > 4'd9 ? ASCII_ERR : ASCII_ZERO + {4'h0, d};
  endfunction
endpackage

// File: rtl/snn_image_buf_if.sv
// snn_image_buf_if: core link (start, addr_input_unit, q_input, done, digit); slave = image buffer, master = snn_core
interface snn_image_buf_if;
  import snn_image_buf_pkg::*;
  logic start;
  logic [ADDR_W-1:0] addr_input_unit;
  logic q_input;
  logic done;
  logic [3:0] digit;
  modport slave(output start, q_input, input addr_input_unit, done, digit);
  modport master(input start, q_input, output addr_input_unit, done, digit);
endinterface

// File: rtl/snn_image_buf_ram.sv
// snn_image_buf_ram: single-port RAM, sync read (clk, we, addr, wdata -> rdata); contents survive reset
module snn_image_buf_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/snn_image_buf.sv
// snn_image_buf: loads 98 UART bytes (rx_data/rx_rdy), kicks core, serves pixels, returns ASCII digit (tx_data/tx_start/tx_busy, busy)
module snn_image_buf
  import snn_image_buf_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             rx_data,
  input  logic                   rx_rdy,
  snn_image_buf_if.slave         core,
  output logic [7:0]             tx_data,
  output logic                   tx_start,
  input  logic                   tx_busy,
  output logic                   busy
);
  img_state_t state, state_nx;
  logic [6:0] byte_cnt, ram_addr;
  logic [7:0] ram_q, tx_hold;
  logic [3:0] res;
  logic [2:0] sel_q;
  logic vld_q, we, last;
  assign we = rx_rdy && state == LOAD;
  assign last = byte_cnt == 7'(NUM_BYTES - 1);
  assign ram_addr = state == LOAD ? byte_cnt : core.addr_input_unit[9:3];
  snn_image_buf_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(7)) u_ram (
    .clk(clk), .we(we), .addr(ram_addr), .wdata(rx_data), .rdata(ram_q)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD;
      byte_cnt <= '0;
      res <= '0;
      sel_q <= '0;
      vld_q <= 1'b0;
      tx_hold <= '0;
    end else begin
      state <= state_nx;
      if (we) byte_cnt <= last ? '0 : byte_cnt + 7'd1;
      if (state == RUN && core.done) res <= core.digit;
      sel_q <= core.addr_input_unit[2:0];
      vld_q <= state == RUN && core.addr_input_unit < ADDR_W'(PIXELS);
      if (tx_start) tx_hold <= to_ascii(res);
    end
  end
  always_comb begin
    state_nx = state;
    case (state)
      LOAD: if (we && last) state_nx = KICK;
      KICK: state_nx = RUN;
      RUN:  if (core.done) state_nx = SEND;
      SEND: if (!tx_busy) state_nx = LOAD;
    endcase
  end
  assign core.start = state == KICK;
  assign core.q_input = vld_q & ram_q[sel_q];
  assign tx_start = state == SEND && !tx_busy;
  assign tx_data = tx_start ? to_ascii(res) : tx_hold;
  assign busy = state != LOAD;
endmodule
